// File: rtl/riscv_bp_ctrl.sv
// rtl/riscv_bp_ctrl.sv - branch-history and predictor-update controller
//
// Owns the speculative global history (GHR) that indexes the predictor read
// port and the committed history (CHR). Carries each branch's history and
// prediction from ID to EX, then issues the registered predictor update and
// the mispredict pulse when the branch resolves.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  pipeline flush; kills the EX branch, GHR <- CHR
//   id_stall_i, id_branch_i  ID stage stall / parcel is a conditional branch
//   id_bp_predict_i          2-bit predictor state read for the ID parcel
//   id_bp_history_i          history used to index that read
//   ex_stall_i               EX stage stall; the EX branch holds
//   ex_btaken_i, ex_pc_i     actual outcome and PC of the EX instruction
//   if_parcel_bp_history_o   GHR, to the predictor read index
//   bu_bp_*_o, bu_pc_o       registered predictor write port
//   bp_mispredict_o          one-cycle mispredict pulse
module riscv_bp_ctrl #(
    parameter int MXLEN          = 32,
    parameter int BP_GLOBAL_BITS = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      id_stall_i,
    input  logic                      id_branch_i,
    input  logic [1:0]                id_bp_predict_i,
    input  logic [BP_GLOBAL_BITS-1:0] id_bp_history_i,
    input  logic                      ex_stall_i,
    input  logic                      ex_btaken_i,
    input  logic [MXLEN-1:0]          ex_pc_i,
    output logic [BP_GLOBAL_BITS-1:0] if_parcel_bp_history_o,
    output logic                      bu_bp_update_o,
    output logic [BP_GLOBAL_BITS-1:0] bu_bp_history_o,
    output logic [1:0]                bu_bp_predict_o,
    output logic                      bu_bp_btaken_o,
    output logic [MXLEN-1:0]          bu_pc_o,
    output logic                      bp_mispredict_o
);

    localparam int G = BP_GLOBAL_BITS;

    // Shift a new bit into the history LSB, dropping the MSB. Also correct
    // for G=1, where the left shift leaves only the new bit.
    function automatic logic [G-1:0] f_shift(input logic [G-1:0] h, input logic b);
        logic [G-1:0] r;
        r    = h << 1;
        r[0] = b;
        return r;
    endfunction

    logic [G-1:0]     r_ghr;
    logic [G-1:0]     r_chr;
    logic             r_ex_vld;
    logic [G-1:0]     r_ex_hist;
    logic [1:0]       r_ex_pred;
    logic             r_upd;
    logic [G-1:0]     r_bu_hist;
    logic [1:0]       r_bu_pred;
    logic             r_bu_btaken;
    logic [MXLEN-1:0] r_bu_pc;
    logic             r_mis;

    logic w_res;
    logic w_mis;
    logic w_spec;

    assign w_res  = r_ex_vld & ~ex_stall_i & ~flush_i;
    // Predictor MSB is the predicted direction (1 = taken).
    assign w_mis  = w_res & (r_ex_pred[1] != ex_btaken_i);
    assign w_spec = id_branch_i & ~id_stall_i & ~ex_stall_i;

    // Speculative and committed history
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ghr <= '0;
            r_chr <= '0;
        end else begin
            if (flush_i)
                r_ghr <= r_chr;
            else if (w_mis)
                r_ghr <= f_shift(r_chr, ex_btaken_i);  // the new committed value
            else if (w_spec)
                r_ghr <= f_shift(r_ghr, id_bp_predict_i[1]);

            if (w_res)
                r_chr <= f_shift(r_chr, ex_btaken_i);
        end
    end

    // ID -> EX capture; a mispredict squashes the wrong-path ID branch
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ex_vld  <= 1'b0;
            r_ex_hist <= '0;
            r_ex_pred <= '0;
        end else if (flush_i) begin
            r_ex_vld  <= 1'b0;
        end else if (!ex_stall_i) begin
            r_ex_vld  <= id_branch_i & ~id_stall_i & ~w_mis;
            r_ex_hist <= id_bp_history_i;
            r_ex_pred <= id_bp_predict_i;
        end
    end

    // Registered update port; data outputs hold between updates
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_upd       <= 1'b0;
            r_mis       <= 1'b0;
            r_bu_hist   <= '0;
            r_bu_pred   <= '0;
            r_bu_btaken <= 1'b0;
            r_bu_pc     <= '0;
        end else begin
            r_upd <= w_res;
            r_mis <= w_mis;
            if (w_res) begin
                r_bu_hist   <= r_ex_hist;
                r_bu_pred   <= r_ex_pred;
                r_bu_btaken <= ex_btaken_i;
                r_bu_pc     <= ex_pc_i;
            end
        end
    end

    assign if_parcel_bp_history_o = r_ghr;
    assign bu_bp_update_o         = r_upd;
    assign bu_bp_history_o        = r_bu_hist;
    assign bu_bp_predict_o        = r_bu_pred;
    assign bu_bp_btaken_o         = r_bu_btaken;
    assign bu_pc_o                = r_bu_pc;
    assign bp_mispredict_o        = r_mis;

endmodule

// File: tb/tb_riscv_bp_ctrl.sv
// tb/tb_riscv_bp_ctrl.sv - self-checking bench for riscv_bp_ctrl
module tb_riscv_bp_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        id_stall_i;
    logic        id_branch_i;
    logic [1:0]  id_bp_predict_i;
    logic [1:0]  id_bp_history_i;
    logic        ex_stall_i;
    logic        ex_btaken_i;
    logic [31:0] ex_pc_i;
    logic [1:0]  if_parcel_bp_history_o;
    logic        bu_bp_update_o;
    logic [1:0]  bu_bp_history_o;
    logic [1:0]  bu_bp_predict_o;
    logic        bu_bp_btaken_o;
    logic [31:0] bu_pc_o;
    logic        bp_mispredict_o;

    int total = 0;
    int bad   = 0;

    riscv_bp_ctrl #(.MXLEN(32), .BP_GLOBAL_BITS(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .id_stall_i(id_stall_i), .id_branch_i(id_branch_i),
        .id_bp_predict_i(id_bp_predict_i), .id_bp_history_i(id_bp_history_i),
        .ex_stall_i(ex_stall_i), .ex_btaken_i(ex_btaken_i), .ex_pc_i(ex_pc_i),
        .if_parcel_bp_history_o(if_parcel_bp_history_o),
        .bu_bp_update_o(bu_bp_update_o), .bu_bp_history_o(bu_bp_history_o),
        .bu_bp_predict_o(bu_bp_predict_o), .bu_bp_btaken_o(bu_bp_btaken_o),
        .bu_pc_o(bu_pc_o), .bp_mispredict_o(bp_mispredict_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        flush;
        logic        id_stall;
        logic        id_br;
        logic [1:0]  id_pred;
        logic [1:0]  id_hist;
        logic        ex_stall;
        logic        ex_bt;
        logic [31:0] pc;
        logic [1:0]  e_ghr;
        logic        e_upd;
        logic        e_mis;
        logic [1:0]  e_hist;
        logic [1:0]  e_pred;
        logic        e_bt;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic ids, input logic idb, input logic [1:0] idp,
                         input logic [1:0] idh, input logic exs, input logic exb, input logic [31:0] pc);
        flush_i = fl; id_stall_i = ids; id_branch_i = idb; id_bp_predict_i = idp;
        id_bp_history_i = idh; ex_stall_i = exs; ex_btaken_i = exb; ex_pc_i = pc;
    endtask

    // Apply inputs for one cycle, then sample #1 after the rising edge.
    task automatic step_chk(input string tag, input logic [1:0] ghr, input logic upd, input logic mis);
        @(posedge clk_i);
        #1;
        chk({tag, ".ghr"}, 32'(if_parcel_bp_history_o), 32'(ghr));
        chk({tag, ".upd"}, 32'(bu_bp_update_o), 32'(upd));
        chk({tag, ".mis"}, 32'(bp_mispredict_o), 32'(mis));
    endtask

    task automatic chk_data(input string tag, input logic [1:0] h, input logic [1:0] p,
                            input logic bt, input logic [31:0] pc);
        chk({tag, ".hist"}, 32'(bu_bp_history_o), 32'(h));
        chk({tag, ".pred"}, 32'(bu_bp_predict_o), 32'(p));
        chk({tag, ".bt"},   32'(bu_bp_btaken_o),  32'(bt));
        chk({tag, ".pc"},   bu_pc_o, pc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ghr"},  32'(if_parcel_bp_history_o), 0);
        chk({tag, ".upd"},  32'(bu_bp_update_o), 0);
        chk({tag, ".mis"},  32'(bp_mispredict_o), 0);
        chk_data(tag, 2'b00, 2'b00, 1'b0, 32'h0);
    endtask

    initial begin
        //            fl ids br pred   hist  exs bt  pc        ghr   upd mis hist  pred  bt  pc
        vecs[0]  = '{0, 0, 0, 2'b00, 2'b00, 0, 0, 32'h0,   2'b00, 0, 0, 2'b00, 2'b00, 0, 32'h0};
        vecs[1]  = '{0, 0, 1, 2'b11, 2'b01, 0, 0, 32'h0,   2'b01, 0, 0, 2'b00, 2'b00, 0, 32'h0};
        vecs[2]  = '{0, 0, 0, 2'b00, 2'b00, 0, 1, 32'h100, 2'b01, 1, 0, 2'b01, 2'b11, 1, 32'h100};
        vecs[3]  = '{0, 0, 0, 2'b00, 2'b00, 0, 0, 32'h0,   2'b01, 0, 0, 2'b00, 2'b00, 0, 32'h0};
        vecs[4]  = '{0, 0, 1, 2'b11, 2'b01, 0, 0, 32'h0,   2'b11, 0, 0, 2'b00, 2'b00, 0, 32'h0};
        vecs[5]  = '{0, 0, 0, 2'b00, 2'b00, 0, 1, 32'h104, 2'b11, 1, 0, 2'b01, 2'b11, 1, 32'h104};
        // mispredict with CHR=11, younger ID branch present
        vecs[6]  = '{0, 0, 1, 2'b10, 2'b11, 0, 0, 32'h0,   2'b11, 0, 0, 2'b00, 2'b00, 0, 32'h0};
        vecs[7]  = '{0, 0, 1, 2'b01, 2'b10, 0, 0, 32'h108, 2'b10, 1, 1, 2'b11, 2'b10, 0, 32'h108};
        vecs[8]  = '{0, 0, 0, 2'b00, 2'b00, 0, 0, 32'h0,   2'b10, 0, 0, 2'b00, 2'b00, 0, 32'h0};
        vecs[9]  = '{0, 0, 0, 2'b00, 2'b00, 0, 1, 32'h0,   2'b10, 0, 0, 2'b00, 2'b00, 0, 32'h0};
        // flush while a branch sits in EX
        vecs[10] = '{0, 0, 1, 2'b11, 2'b10, 0, 0, 32'h0,   2'b01, 0, 0, 2'b00, 2'b00, 0, 32'h0};
        vecs[11] = '{1, 0, 1, 2'b11, 2'b01, 0, 1, 32'h1F0, 2'b10, 0, 0, 2'b00, 2'b00, 0, 32'h0};
        vecs[12] = '{0, 0, 0, 2'b00, 2'b00, 0, 1, 32'h1F4, 2'b10, 0, 0, 2'b00, 2'b00, 0, 32'h0};
        // three back-to-back branches
        vecs[13] = '{0, 0, 1, 2'b11, 2'b10, 0, 0, 32'h0,   2'b01, 0, 0, 2'b00, 2'b00, 0, 32'h0};
        vecs[14] = '{0, 0, 1, 2'b00, 2'b01, 0, 1, 32'h200, 2'b10, 1, 0, 2'b10, 2'b11, 1, 32'h200};
        vecs[15] = '{0, 0, 1, 2'b11, 2'b10, 0, 0, 32'h204, 2'b01, 1, 0, 2'b01, 2'b00, 0, 32'h204};
        vecs[16] = '{0, 0, 0, 2'b00, 2'b00, 0, 1, 32'h208, 2'b01, 1, 0, 2'b10, 2'b11, 1, 32'h208};
        vecs[17] = '{0, 0, 0, 2'b00, 2'b00, 0, 0, 32'h0,   2'b01, 0, 0, 2'b00, 2'b00, 0, 32'h0};

        rst_ni = 1'b0;
        drive(0, 0, 0, 2'b00, 2'b00, 0, 0, 32'h0);
        #1;
        chk_all_zero("reset");
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].flush, vecs[i].id_stall, vecs[i].id_br, vecs[i].id_pred,
                  vecs[i].id_hist, vecs[i].ex_stall, vecs[i].ex_bt, vecs[i].pc);
            step_chk($sformatf("v%0d", i), vecs[i].e_ghr, vecs[i].e_upd, vecs[i].e_mis);
            if (vecs[i].e_upd)
                chk_data($sformatf("v%0d", i), vecs[i].e_hist, vecs[i].e_pred, vecs[i].e_bt, vecs[i].e_pc);
        end

        // EX stall: CHR=01, GHR=01 here. Branch A enters EX, branch B waits in ID.
        drive(0, 0, 1, 2'b11, 2'b01, 0, 0, 32'h0);
        step_chk("stl.cap", 2'b11, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 2'b00, 2'b11, 1, 1, 32'h300);
            step_chk($sformatf("stl.hold%0d", i), 2'b11, 0, 0);
        end
        drive(0, 0, 1, 2'b00, 2'b11, 0, 1, 32'h300);
        step_chk("stl.resA", 2'b10, 1, 0);
        chk_data("stl.resA", 2'b01, 2'b11, 1'b1, 32'h300);
        drive(0, 0, 0, 2'b00, 2'b00, 0, 0, 32'h304);
        step_chk("stl.resB", 2'b10, 1, 0);
        chk_data("stl.resB", 2'b11, 2'b00, 1'b0, 32'h304);
        drive(0, 0, 0, 2'b00, 2'b00, 0, 0, 32'h0);
        step_chk("stl.idle", 2'b10, 0, 0);

        // Reset mid-operation with a branch in EX
        drive(0, 0, 1, 2'b11, 2'b10, 0, 1, 32'h400);
        step_chk("rst.cap", 2'b01, 0, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_all_zero("rst.mid");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        drive(0, 0, 0, 2'b00, 2'b00, 0, 1, 32'h400);
        step_chk("rst.post0", 2'b00, 0, 0);
        step_chk("rst.post1", 2'b00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
